// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, instruction field positions
// and the default reset PC.
package fetch_pkg;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

    localparam int unsigned DEFAULT_INSTR_W = 32;

    // Field positions for a DEFAULT_INSTR_W-wide instruction
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 30;
    localparam int unsigned INST_MSB = 29;
    localparam int unsigned INST_LSB = 28;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register used while decode stalls.
// Clear wins over load.
module fetch_skid_buffer #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic               full,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack instruction-memory fetch, IF/ID register,
// stall handling through a one-entry skid buffer and jump redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned      PC_W     = 32,
    parameter int unsigned      INSTR_W  = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               if_stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic [1:0]         if_op,
    output logic [1:0]         if_inst
);

    // Field positions are defined for the default width; keep them MSB-relative
    localparam int FIELD_SHIFT = int'(INSTR_W) - int'(DEFAULT_INSTR_W);
    localparam int OP_HI       = int'(OP_MSB) + FIELD_SHIFT;
    localparam int OP_LO       = int'(OP_LSB) + FIELD_SHIFT;
    localparam int INST_HI     = int'(INST_MSB) + FIELD_SHIFT;
    localparam int INST_LO     = int'(INST_LSB) + FIELD_SHIFT;

    fetch_state_e       state;
    logic [PC_W-1:0]    pc;
    logic               skid_load;
    logic               skid_clear;
    logic               skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    // A redirect drops the request so the stale address is never acked
    assign imem_req   = (state == REQ) && !rst && !redirect;
    assign imem_addr  = pc;

    assign skid_load  = !rst && !redirect && (state == REQ) && imem_ack && if_stall;
    assign skid_clear = rst || redirect || ((state == HOLD) && !if_stall);

    fetch_skid_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .full       (skid_full),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (redirect) begin
            state    <= REQ;
            pc       <= redirect_pc;
            if_valid <= 1'b0;
        end else begin
            unique case (state)
                REQ: begin
                    if (!if_stall) begin
                        if (imem_ack) begin
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= pc + PC_W'(1);
                        end else begin
                            if_valid <= 1'b0;
                        end
                    end else if (imem_ack) begin
                        pc    <= pc + PC_W'(1);
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!if_stall) begin
                        if_instr <= skid_instr;
                        if_pc    <= skid_pc;
                        if_valid <= 1'b1;
                        state    <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    assign if_op   = if_instr[OP_HI:OP_LO];
    assign if_inst = if_instr[INST_HI:INST_LO];

    addr_stable_a : assert property (@(posedge clk) disable iff (rst)
        (imem_req && !imem_ack) |=> $stable(imem_addr));

    hold_has_skid_a : assert property (@(posedge clk) disable iff (rst)
        (state == HOLD) |-> skid_full);

endmodule
